// File: rtl/scalar_branch_resolve.sv
// Branch resolution: flag register, condition evaluation, PC redirect handshake and post-redirect flush.
// Optional statistics counters are built when SCALAR_BR_STATS_EN is defined.
module scalar_branch_resolve #(
    parameter int unsigned DATA_W       = 36,
    parameter int unsigned IMM_W        = 25,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic              ex_zero,
    input  logic              ex_sign,
    input  logic              ex_overflow,
    input  logic              ex_is_branch,
    input  logic              ex_is_jr,
    input  logic [2:0]        ex_cond,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [IMM_W-1:0]  ex_offset,
    input  logic [DATA_W-1:0] ex_target_reg,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [DATA_W-1:0] redir_pc,
    output logic              flush,
    output logic              stall,
    output logic [2:0]        flags,
    output logic [31:0]       br_count,
    output logic [31:0]       taken_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   flush_cnt;

    logic               eff_z;
    logic               eff_s;
    logic               eff_o;
    logic               cond_ok;
    logic               accept;
    logic               is_ctrl;
    logic               taken;
    logic [DATA_W-1:0]  target;

    // Evaluation flags bypass the register when this instruction also writes them
    always_comb begin
        eff_z = flags[0];
        eff_s = flags[1];
        eff_o = flags[2];
        if (ex_set_flags) begin
            eff_z = ex_zero;
            eff_s = ex_sign;
            eff_o = ex_overflow;
        end
    end

    always_comb begin
        cond_ok = 1'b1;
        case (ex_cond)
            3'd0:    cond_ok = !eff_z;
            3'd1:    cond_ok = eff_z;
            3'd2:    cond_ok = !eff_z && (eff_s == eff_o);
            3'd3:    cond_ok = eff_s != eff_o;
            3'd4:    cond_ok = eff_s == eff_o;
            3'd5:    cond_ok = eff_z || (eff_s != eff_o);
            3'd6:    cond_ok = eff_o;
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && ex_valid;
        is_ctrl = ex_is_branch || ex_is_jr;
        taken  = accept && (ex_is_jr || (ex_is_branch && cond_ok));
        target = ex_is_jr ? ex_target_reg
                          : ex_pc + DATA_W'(1) + DATA_W'($signed(ex_offset));
    end

    // Redirect FSM; redir_valid/flush/stall are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush       <= 1'b0;
            stall       <= 1'b0;
            flags       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && ex_set_flags) begin
                        flags <= {ex_overflow, ex_sign, ex_zero};
                    end
                    if (taken) begin
                        state       <= REDIRECT;
                        redir_pc    <= target;
                        redir_valid <= 1'b1;
                        flush       <= 1'b1;
                        stall       <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state <= IDLE;
                            flush <= 1'b0;
                            stall <= 1'b0;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                        stall <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                    flush       <= 1'b0;
                    stall       <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCALAR_BR_STATS_EN
    // Accepted control-flow instructions and the taken subset; both wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (accept && is_ctrl) begin
                br_count <= br_count + 32'd1;
            end
            if (taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`else
    assign br_count    = '0;
    assign taken_count = '0;
`endif

endmodule
